fir_acc_mc: RTL and testbench
=============================

FIR_ACC_MC -- requirements
Module: fir_acc_mc

Interface
REQ-001 SHALL provide parameter IN_W, default 21, width of the summed-product input and committed result.
REQ-002 SHALL provide parameter ACC_W, default 25, accumulator width; legal only if ACC_W >= IN_W.
REQ-003 SHALL provide parameter N_CH, default 4, number of independent accumulator channels (>= 2); CH_W = clog2(N_CH), derived.
REQ-004 SHALL provide ports, exactly as listed:
- clk_b  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- FSM_reset_Acc  in  1  clear the accumulator of channel acc_ch
- FSM_Acc_en  in  1  add suma_wynik to the accumulator of channel acc_ch
- FSM_Acc_zapis  in  1  commit the accumulator of channel acc_ch to the output register
- acc_ch  in  CH_W  channel select for all three commands
- suma_wynik  in  IN_W  signed two's-complement addend
- wynik_ready  in  1  downstream accepts the result
- Acc_out  out  ACC_W  registered value of channel acc_ch, combinational mux
- FIR_probka_wynik  out  IN_W  committed result
- wynik_ch  out  CH_W  channel of the committed result
- wynik_valid  out  1  result is held and valid
- acc_ovf  out  N_CH  sticky overflow flag per channel
- zapis_drop  out  1  one-cycle pulse: commit refused

Function
REQ-005 SHALL hold N_CH signed ACC_W accumulators; suma_wynik is sign-extended to ACC_W before adding.
REQ-006 FSM_Acc_en alone SHALL update acc[acc_ch] <= acc[acc_ch] + ext(suma_wynik) at the next edge; other channels unchanged.
REQ-007 FSM_reset_Acc alone SHALL set acc[acc_ch] to 0 and clear acc_ovf[acc_ch] at the next edge.
REQ-008 FSM_reset_Acc together with FSM_Acc_en SHALL load acc[acc_ch] with ext(suma_wynik) and clear acc_ovf[acc_ch].
REQ-009 Signed overflow of an ACC_W addition SHALL set acc_ovf[acc_ch]; the flag stays set until cleared per REQ-007/008 or reset.
REQ-010 FSM_Acc_zapis SHALL sample the pre-update value of acc[acc_ch], even when FSM_Acc_en or FSM_reset_Acc is asserted in the same cycle.
REQ-011 The output path SHALL be a two-state FSM: EMPTY (wynik_valid=0) and FULL (wynik_valid=1).
REQ-012 In EMPTY, FSM_Acc_zapis SHALL load FIR_probka_wynik and wynik_ch and move to FULL; wynik_valid rises one cycle after the command.
REQ-013 In FULL with wynik_ready=1 and no commit, the FSM SHALL transfer and return to EMPTY at the next edge.
REQ-014 In FULL with wynik_ready=1 and a commit, the FSM SHALL transfer the old value, load the new one and stay FULL (no bubble).
REQ-015 In FULL with wynik_ready=0, a commit SHALL be refused: outputs unchanged, zapis_drop=1 for exactly the following cycle.
REQ-016 Narrowing ACC_W to IN_W at commit SHALL follow REQ-022/023; FIR_probka_wynik and wynik_ch SHALL stay stable while FULL.

Reset
REQ-017 rst_n=0 at an edge SHALL zero all accumulators, acc_ovf, FIR_probka_wynik, wynik_ch, wynik_valid and zapis_drop, and put the FSM in EMPTY.
REQ-018 Reset SHALL take priority over every command in the same cycle, including an operation in progress or a held result.
REQ-019 Acc_out SHALL read 0 for every acc_ch from the first edge after reset.

Configuration
REQ-020 Saturation SHALL be compiled in by macro FIR_ACC_SAT_EN.
REQ-021 The acc_ovf setting of REQ-009 SHALL be independent of FIR_ACC_SAT_EN.
REQ-022 With FIR_ACC_SAT_EN defined, an overflowing addition SHALL clamp to +(2^(ACC_W-1)-1) or -2^(ACC_W-1); the commit SHALL clamp to the IN_W signed range.
REQ-023 Without FIR_ACC_SAT_EN, the addition SHALL wrap modulo 2^ACC_W; the commit SHALL take the low IN_W bits.

Verification
REQ-024 Reset: rst_n=0 for 2 cycles with en=1, suma_wynik=5 -> all Acc_out=0, wynik_valid=0, acc_ovf=0.
REQ-025 Accumulate: ch0 reset, then en with 5,6,7 -> Acc_out=18; zapis on ch0 with ready=1 -> FIR_probka_wynik=18, wynik_ch=0, wynik_valid high for exactly one cycle.
REQ-026 Channel isolation: ch1 +100, ch2 -50, ch1 +1, interleaved -> ch1=101, ch2=-50, ch0 still 18.
REQ-027 Backpressure: ready=0, commit ch1 then commit ch2 -> zapis_drop pulse, output stays 101; then ready=1 with a ch2 commit in the same cycle -> 101 transferred, -50 loaded, wynik_valid stays 1.
REQ-028 Overflow: ch3 adds 1048575 seventeen times -> acc_ovf[3]=1; SAT build: Acc_out=16777215 and commit gives 1048575; non-SAT build: Acc_out=-15728657.
REQ-029 Load: reset+en on ch3 with 9 -> Acc_out=9, acc_ovf[3]=0.

Source files
------------

// File: rtl/fir_acc_mc.sv
// Multi-channel signed accumulator with a one-deep handshaked result register.
// Optional saturation of accumulation and commit narrowing: define FIR_ACC_SAT_EN.
module fir_acc_mc #(
  parameter  int IN_W  = 21,
  parameter  int ACC_W = 25,
  parameter  int N_CH  = 4,
  localparam int CH_W  = $clog2(N_CH)
) (
  input  logic              clk_b,
  input  logic              rst_n,
  input  logic              FSM_reset_Acc,
  input  logic              FSM_Acc_en,
  input  logic              FSM_Acc_zapis,
  input  logic [CH_W-1:0]   acc_ch,
  input  logic [IN_W-1:0]   suma_wynik,
  input  logic              wynik_ready,
  output logic [ACC_W-1:0]  Acc_out,
  output logic [IN_W-1:0]   FIR_probka_wynik,
  output logic [CH_W-1:0]   wynik_ch,
  output logic              wynik_valid,
  output logic [N_CH-1:0]   acc_ovf,
  output logic              zapis_drop
);

  typedef enum logic {EMPTY, FULL} state_t;

`ifdef FIR_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] IN_MAX  = ACC_W'(signed'({1'b0, {(IN_W-1){1'b1}}}));
  localparam logic signed [ACC_W-1:0] IN_MIN  = ACC_W'(signed'({1'b1, {(IN_W-1){1'b0}}}));
`endif

  logic signed [ACC_W-1:0] acc [N_CH];
  logic [N_CH-1:0]         ovf_q;
  state_t                  state, state_next;
  logic [IN_W-1:0]         res_q;
  logic [CH_W-1:0]         res_ch_q;
  logic                    drop_q, drop_d, load;

  logic signed [ACC_W-1:0] acc_sel, ext, base, sum, acc_next;
  logic                    ovf_det;
  logic [IN_W-1:0]         narrow;

  // A clear in the same cycle as an add makes the add start from zero (load).
  always_comb begin
    acc_sel  = acc[acc_ch];
    ext      = ACC_W'(signed'(suma_wynik));
    base     = FSM_reset_Acc ? '0 : acc_sel;
    sum      = base + ext;
    ovf_det  = (base[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
    acc_next = sum;
`ifdef FIR_ACC_SAT_EN
    if (ovf_det) acc_next = base[ACC_W-1] ? ACC_MIN : ACC_MAX;
    if (acc_sel > IN_MAX)      narrow = IN_MAX[IN_W-1:0];
    else if (acc_sel < IN_MIN) narrow = IN_MIN[IN_W-1:0];
    else                       narrow = acc_sel[IN_W-1:0];
`else
    narrow   = acc_sel[IN_W-1:0];
`endif
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    drop_d     = 1'b0;
    unique case (state)
      EMPTY: if (FSM_Acc_zapis) begin
        load       = 1'b1;
        state_next = FULL;
      end
      FULL: begin
        if (wynik_ready) begin
          load = FSM_Acc_zapis;
          if (!FSM_Acc_zapis) state_next = EMPTY;
        end else begin
          drop_d = FSM_Acc_zapis;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk_b) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_CH; i++) acc[i] <= '0;
      ovf_q    <= '0;
      state    <= EMPTY;
      res_q    <= '0;
      res_ch_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      if (FSM_reset_Acc || FSM_Acc_en) begin
        acc[acc_ch]   <= FSM_Acc_en ? acc_next : '0;
        ovf_q[acc_ch] <= FSM_reset_Acc ? 1'b0 : (ovf_q[acc_ch] | ovf_det);
      end
      state  <= state_next;
      drop_q <= drop_d;
      if (load) begin
        res_q    <= narrow;
        res_ch_q <= acc_ch;
      end
    end
  end

  assign Acc_out          = acc_sel;
  assign FIR_probka_wynik = res_q;
  assign wynik_ch         = res_ch_q;
  assign wynik_valid      = (state == FULL);
  assign acc_ovf          = ovf_q;
  assign zapis_drop       = drop_q;

endmodule

// File: tb/tb_fir_acc_mc.sv
// Bench for fir_acc_mc: directed scenarios plus randomized traffic against an
// arithmetic reference model; honours FIR_ACC_SAT_EN like the design.
module tb_fir_acc_mc;
  localparam int IN_W  = 21;
  localparam int ACC_W = 25;
  localparam int N_CH  = 4;
  localparam int CH_W  = 2;
`ifdef FIR_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam longint ACC_MOD = 64'sd1 <<< ACC_W;
  localparam longint ACC_MAX = (64'sd1 <<< (ACC_W-1)) - 1;
  localparam longint ACC_MIN = -(64'sd1 <<< (ACC_W-1));
  localparam longint IN_MOD  = 64'sd1 <<< IN_W;
  localparam longint IN_MAX  = (64'sd1 <<< (IN_W-1)) - 1;
  localparam longint IN_MIN  = -(64'sd1 <<< (IN_W-1));

  logic clk_b = 1'b0;
  logic rst_n, FSM_reset_Acc, FSM_Acc_en, FSM_Acc_zapis, wynik_ready;
  logic [CH_W-1:0]  acc_ch;
  logic [IN_W-1:0]  suma_wynik;
  logic [ACC_W-1:0] Acc_out;
  logic [IN_W-1:0]  FIR_probka_wynik;
  logic [CH_W-1:0]  wynik_ch;
  logic             wynik_valid;
  logic [N_CH-1:0]  acc_ovf;
  logic             zapis_drop;

  int vectors = 0;
  int miscompares = 0;

  longint m_acc [N_CH];
  bit     m_ovf [N_CH];
  bit     m_valid, m_drop;
  longint m_res;
  int     m_ch;

  fir_acc_mc #(.IN_W(IN_W), .ACC_W(ACC_W), .N_CH(N_CH)) dut (
    .clk_b(clk_b), .rst_n(rst_n), .FSM_reset_Acc(FSM_reset_Acc),
    .FSM_Acc_en(FSM_Acc_en), .FSM_Acc_zapis(FSM_Acc_zapis), .acc_ch(acc_ch),
    .suma_wynik(suma_wynik), .wynik_ready(wynik_ready), .Acc_out(Acc_out),
    .FIR_probka_wynik(FIR_probka_wynik), .wynik_ch(wynik_ch),
    .wynik_valid(wynik_valid), .acc_ovf(acc_ovf), .zapis_drop(zapis_drop)
  );

  always #5 clk_b = ~clk_b;

  function automatic longint narrow(input longint v);
    longint r;
    if (SAT) begin
      r = (v > IN_MAX) ? IN_MAX : (v < IN_MIN) ? IN_MIN : v;
    end else begin
      r = v % IN_MOD;
      if (r < 0) r += IN_MOD;
      if (r > IN_MAX) r -= IN_MOD;
    end
    return r;
  endfunction

  function automatic longint acc_val();
    return longint'($signed(Acc_out));
  endfunction

  function automatic logic [N_CH-1:0] exp_ovf();
    logic [N_CH-1:0] v;
    for (int i = 0; i < N_CH; i++) v[i] = m_ovf[i];
    return v;
  endfunction

  // Drive one cycle of commands, clock it, then advance the model.
  task automatic cycle(input bit rst, input bit rs, input bit en, input bit zp,
                       input int ch, input longint x, input bit rdy);
    logic [IN_W-1:0] xb;
    longint s, nv;
    xb = x[IN_W-1:0];
    rst_n = rst; FSM_reset_Acc = rs; FSM_Acc_en = en; FSM_Acc_zapis = zp;
    acc_ch = CH_W'(ch); suma_wynik = xb; wynik_ready = rdy;
    @(posedge clk_b); #1;
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin m_acc[i] = 0; m_ovf[i] = 0; end
      m_valid = 0; m_drop = 0; m_res = 0; m_ch = 0;
    end else begin
      nv = narrow(m_acc[ch]);
      m_drop = 0;
      if (!m_valid) begin
        if (zp) begin m_valid = 1; m_res = nv; m_ch = ch; end
      end else if (rdy) begin
        if (zp) begin m_res = nv; m_ch = ch; end
        else m_valid = 0;
      end else begin
        m_drop = zp;
      end
      if (rs) begin
        m_acc[ch] = en ? x : 0;
        m_ovf[ch] = 0;
      end else if (en) begin
        s = m_acc[ch] + x;
        if (s > ACC_MAX) begin m_ovf[ch] = 1; s = SAT ? ACC_MAX : s - ACC_MOD; end
        if (s < ACC_MIN) begin m_ovf[ch] = 1; s = SAT ? ACC_MIN : s + ACC_MOD; end
        m_acc[ch] = s;
      end
    end
  endtask

  task automatic test_reset();
    cycle(0, 0, 1, 0, 0, 5, 1);
    cycle(0, 0, 1, 0, 0, 5, 1);
    vectors++;
    if (wynik_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b want 0", wynik_valid); end
    vectors++;
    if (acc_ovf !== '0) begin miscompares++; $display("FAIL reset_ovf got %b want 0", acc_ovf); end
    vectors++;
    if (zapis_drop !== 1'b0 || FIR_probka_wynik !== '0 || wynik_ch !== '0) begin
      miscompares++; $display("FAIL reset_out got drop=%0b res=%0d ch=%0d want 0", zapis_drop, FIR_probka_wynik, wynik_ch);
    end
    for (int c = 0; c < N_CH; c++) begin
      acc_ch = CH_W'(c); #1;
      vectors++;
      if (Acc_out !== '0) begin miscompares++; $display("FAIL reset_acc ch%0d got %0d want 0", c, Acc_out); end
    end
  endtask

  task automatic test_accumulate();
    cycle(1, 1, 0, 0, 0, 0, 1);
    cycle(1, 0, 1, 0, 0, 5, 1);
    cycle(1, 0, 1, 0, 0, 6, 1);
    cycle(1, 0, 1, 0, 0, 7, 1);
    vectors++;
    if (acc_val() !== 64'sd18) begin miscompares++; $display("FAIL accum_sum got %0d want 18", acc_val()); end
    cycle(1, 0, 0, 1, 0, 0, 1);
    vectors++;
    if (wynik_valid !== 1'b1 || FIR_probka_wynik !== IN_W'(18) || wynik_ch !== 2'd0) begin
      miscompares++; $display("FAIL accum_commit got v=%0b res=%0d ch=%0d want v=1 res=18 ch=0", wynik_valid, FIR_probka_wynik, wynik_ch);
    end
    cycle(1, 0, 0, 0, 0, 0, 1);
    vectors++;
    if (wynik_valid !== 1'b0) begin miscompares++; $display("FAIL accum_valid_pulse got %0b want 0", wynik_valid); end
  endtask

  task automatic test_channels();
    longint want [3] = '{18, 101, -50};
    cycle(1, 0, 1, 0, 1, 100, 1);
    cycle(1, 0, 1, 0, 2, -50, 1);
    cycle(1, 0, 1, 0, 1, 1, 1);
    for (int c = 0; c < 3; c++) begin
      acc_ch = CH_W'(c); #1;
      vectors++;
      if (acc_val() !== want[c]) begin miscompares++; $display("FAIL chan_iso ch%0d got %0d want %0d", c, acc_val(), want[c]); end
    end
  endtask

  task automatic test_backpressure();
    logic [IN_W-1:0] neg50;
    neg50 = IN_W'(-50);
    cycle(1, 0, 0, 1, 1, 0, 0);
    vectors++;
    if (wynik_valid !== 1'b1 || FIR_probka_wynik !== IN_W'(101) || wynik_ch !== 2'd1 || zapis_drop !== 1'b0) begin
      miscompares++; $display("FAIL bp_load got v=%0b res=%0d ch=%0d drop=%0b want 1/101/1/0", wynik_valid, FIR_probka_wynik, wynik_ch, zapis_drop);
    end
    cycle(1, 0, 0, 1, 2, 0, 0);
    vectors++;
    if (zapis_drop !== 1'b1 || FIR_probka_wynik !== IN_W'(101) || wynik_ch !== 2'd1 || wynik_valid !== 1'b1) begin
      miscompares++; $display("FAIL bp_drop got drop=%0b res=%0d ch=%0d v=%0b want 1/101/1/1", zapis_drop, FIR_probka_wynik, wynik_ch, wynik_valid);
    end
    cycle(1, 0, 0, 1, 2, 0, 1);
    vectors++;
    if (zapis_drop !== 1'b0 || FIR_probka_wynik !== neg50 || wynik_ch !== 2'd2 || wynik_valid !== 1'b1) begin
      miscompares++; $display("FAIL bp_nobubble got drop=%0b res=%0h ch=%0d v=%0b want 0/%0h/2/1", zapis_drop, FIR_probka_wynik, wynik_ch, wynik_valid, neg50);
    end
    cycle(1, 0, 0, 0, 0, 0, 1);
    vectors++;
    if (wynik_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain got %0b want 0", wynik_valid); end
  endtask

  task automatic test_overflow();
    longint want_acc, want_res;
    want_acc = SAT ? 64'sd16777215 : -64'sd15728657;
    want_res = SAT ? 64'sd1048575 : 64'sd1048559;
    cycle(1, 1, 0, 0, 3, 0, 1);
    for (int i = 0; i < 17; i++) cycle(1, 0, 1, 0, 3, 1048575, 1);
    vectors++;
    if (acc_ovf[3] !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %0b want 1", acc_ovf[3]); end
    vectors++;
    if (acc_val() !== want_acc) begin miscompares++; $display("FAIL ovf_acc got %0d want %0d", acc_val(), want_acc); end
    cycle(1, 0, 0, 1, 3, 0, 1);
    vectors++;
    if (longint'($signed(FIR_probka_wynik)) !== want_res || wynik_ch !== 2'd3) begin
      miscompares++; $display("FAIL ovf_commit got %0d ch=%0d want %0d ch=3", $signed(FIR_probka_wynik), wynik_ch, want_res);
    end
    cycle(1, 0, 0, 0, 3, 0, 1);
  endtask

  task automatic test_load();
    cycle(1, 1, 1, 0, 3, 9, 1);
    vectors++;
    if (acc_val() !== 64'sd9 || acc_ovf[3] !== 1'b0) begin
      miscompares++; $display("FAIL load got acc=%0d ovf=%0b want 9/0", acc_val(), acc_ovf[3]);
    end
  endtask

  task automatic test_random();
    longint x;
    int ch;
    for (int n = 0; n < 400; n++) begin
      ch = $urandom_range(0, N_CH-1);
      if ($urandom_range(0, 3) == 0) x = ($urandom_range(0, 1) == 1) ? IN_MAX : IN_MIN;
      else x = longint'($urandom_range(0, 32'(IN_MOD - 1))) + IN_MIN;
      cycle($urandom_range(0, 59) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0, ch, x, $urandom_range(0, 2) != 0);
      vectors++;
      if (acc_val() !== m_acc[ch] || acc_ovf !== exp_ovf() || wynik_valid !== m_valid ||
          zapis_drop !== m_drop || (m_valid && (longint'($signed(FIR_probka_wynik)) !== m_res || wynik_ch !== CH_W'(m_ch)))) begin
        miscompares++;
        $display("FAIL rand n=%0d got acc=%0d ovf=%b v=%0b drop=%0b res=%0d ch=%0d want acc=%0d ovf=%b v=%0b drop=%0b res=%0d ch=%0d",
                 n, acc_val(), acc_ovf, wynik_valid, zapis_drop, $signed(FIR_probka_wynik), wynik_ch,
                 m_acc[ch], exp_ovf(), m_valid, m_drop, m_res, m_ch);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; FSM_reset_Acc = 1'b0; FSM_Acc_en = 1'b0; FSM_Acc_zapis = 1'b0;
    acc_ch = '0; suma_wynik = '0; wynik_ready = 1'b0;
    test_reset();
    test_accumulate();
    test_channels();
    test_backpressure();
    test_overflow();
    test_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
